// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dff_pipe_pkg                                               |
// | Description : Shared defaults and width helper for the dff_pipe          |
// |               register pipeline.                                         |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
package dff_pipe_pkg;

  localparam int DFF_PIPE_DEF_WIDTH = 8;
  localparam int DFF_PIPE_DEF_DEPTH = 4;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dff_stage                                                  |
// | Description : One pipeline stage: WIDTH-bit data register plus valid     |
// |               bit. Valid follows the source when enabled; data only      |
// |               loads when the source word is valid, so bubbles never      |
// |               overwrite the last good value.                             |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
module dff_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DFF_PIPE_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_src_valid,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Stage register: reset, clear (valid only), or advance when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_src_valid;
      if (i_src_valid) begin
        r_data <= i_src_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dff_pipe                                                   |
// | Description : WIDTH-bit, DEPTH-stage elastic register pipeline with      |
// |               per-stage valid, collapsing bubbles and valid/ready        |
// |               backpressure. Optional macro DFF_PIPE_FLUSH_EN adds a      |
// |               flush input that drops all in-flight words.                |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DFF_PIPE_DEF_WIDTH,
  parameter int               DEPTH     = DFF_PIPE_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count
`ifdef DFF_PIPE_FLUSH_EN
  ,
  input  logic                      flush
`endif
);

  localparam int                c_cnt_w = cnt_w(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             w_clr;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [c_cnt_w-1:0] r_count;

`ifdef DFF_PIPE_FLUSH_EN
  assign w_clr = flush;
`else
  assign w_clr = 1'b0;
`endif

  // The last stage drains whenever downstream is ready.
  assign w_rdy[DEPTH] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             w_src_valid;
      logic [WIDTH-1:0] w_src_data;

      // A stage may load if it is empty or the stage ahead will take its word.
      assign w_rdy[gi] = ~w_valid[gi] | w_rdy[gi+1];

      if (gi == 0) begin : g_first
        assign w_src_valid = in_valid;
        assign w_src_data  = in_data;
      end else begin : g_rest
        assign w_src_valid = w_valid[gi-1];
        assign w_src_data  = w_data[gi-1];
      end

      dff_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk         (clk),
        .rst         (reset),
        .i_en        (w_rdy[gi]),
        .i_clr       (w_clr),
        .i_src_valid (w_src_valid),
        .i_src_data  (w_src_data),
        .o_valid     (w_valid[gi]),
        .o_data      (w_data[gi])
      );
    end
  endgenerate

  // No word is accepted while a flush is clearing the pipeline.
  assign in_ready   = w_rdy[0] & ~w_clr;
  assign out_valid  = w_valid[DEPTH-1];
  assign out_data   = w_data[DEPTH-1];
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Occupancy counter tracks input/output transfers.
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_count <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_count <= r_count + c_one;
    end else if (w_out_xfer && !w_in_xfer) begin
      r_count <= r_count - c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dff_pipe                                                |
// | Description : Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       count;
  logic             flush = 1'b0;

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;
  bit rnd = 1'b0;
  int exp_cnt = 0;
  logic [WIDTH-1:0] sb_q[$];

  dff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef DFF_PIPE_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard push side: record every accepted word; reset/flush drop everything.
  always @(negedge clk) begin
    if (armed) begin
      if (reset || flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  // Scoreboard pop side: every output transfer must match the oldest accepted word.
  always @(negedge clk) begin
    if (armed && !reset && !flush && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: got %0h with nothing expected at %0t", out_data, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = sb_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_word: got %0h expected %0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  // Occupancy / ready model.
  always @(negedge clk) begin
    if (!armed) begin
      exp_cnt = 0;
    end else begin
      bit exp_rdy;
      exp_rdy = !flush && ((exp_cnt < DEPTH) || out_ready);
      chk("count", 32'(count), 32'(exp_cnt));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (reset || flush) exp_cnt = 0;
      else if ((in_valid && exp_rdy) && !(out_valid && out_ready)) exp_cnt++;
      else if (!(in_valid && exp_rdy) && (out_valid && out_ready)) exp_cnt--;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      acc = in_ready;
      cyc();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((sb_q.size() != 0 || count != 0) && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_queue", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    // Reset for two edges.
    cyc();
    cyc();
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming with no backpressure: first word visible after the 4th edge.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      cyc();
      if (k == 2) chk("lat_not_yet", 32'(out_valid), 32'd0);
      if (k == 3) begin
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h01);
        chk("stream_count", 32'(count), 32'd4);
      end
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: fill with A1..A4, A5 must be held off.
    out_ready = 1'b0;
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    send(8'hA4);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    cyc();
    cyc();
    cyc();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_data", 32'(out_data), 32'hA1);
    out_ready = 1'b1;
    send(8'hA5);

    // Full with simultaneous input and output transfers.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hB1 + k);
      @(negedge clk);
      chk("full_pass_rdy", 32'(in_ready), 32'd1);
      cyc();
      chk("full_pass_count", 32'(count), 32'd4);
    end
    in_valid = 1'b0;
    drain();

    // Gappy input with random backpressure.
    rnd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      send(8'(8'h10 + k));
      cyc();
      out_ready = 1'($urandom_range(0, 1));
    end
    rnd = 1'b0;
    drain();

    // Reset with three words in flight.
    out_ready = 1'b0;
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    cyc();
    cyc();
    chk("mid_count", 32'(count), 32'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'h00);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);

`ifdef DFF_PIPE_FLUSH_EN
    // Flush with three words in flight: data registers keep their contents.
    send(8'hD1);
    send(8'hD2);
    send(8'hD3);
    cyc();
    cyc();
    chk("pre_flush_data", 32'(out_data), 32'hD1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", 32'(out_data), 32'hD1);
`endif

    drain();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
